// File: rtl/fp_add_normalize_if.sv
// Handshake and data bundle for the floating-point add/normalize block.
// The master side supplies operands and the downstream ready; the slave
// side (the block itself) returns the input ready and the packed result.
interface fp_add_normalize_if;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] signeda;
  logic [24:0] signedb;
  logic        sign_a;
  logic        sign_b;
  logic [7:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_o;

  modport master (
    output in_valid, signeda, signedb, sign_a, sign_b, exp_in, out_ready,
    input  in_ready, out_valid, result_o
  );

  modport slave (
    input  in_valid, signeda, signedb, sign_a, sign_b, exp_in, out_ready,
    output in_ready, out_valid, result_o
  );
endinterface

// File: rtl/fp_add_normalize.sv
// Two-stage single-precision mantissa adder with normalization and packing.
// Stage 1 adds the two's-complement aligned mantissas and forms a sign and
// magnitude; stage 2 normalizes by truncation, handles zero, overflow to
// infinity and underflow flush-to-zero, then packs the IEEE-754 word.
// Each stage is a valid-qualified register that loads when empty or when its
// contents move on in the same cycle, giving full throughput and a two-deep
// skid under backpressure.
module fp_add_normalize (
  input  logic              clk,
  input  logic              rst_n,
  fp_add_normalize_if.slave bus
);

  logic        s1_valid_q;
  logic [25:0] s1_mag_q;
  logic        s1_sign_q;
  logic [7:0]  s1_exp_q;

  logic        s2_valid_q;
  logic [31:0] result_q;

  logic        s1_load;
  logic        s2_load;

  logic [25:0] sum_d;
  logic [25:0] mag_d;
  logic        sign_d;

  logic [4:0]        lead;
  logic [4:0]        shamt;
  logic [22:0]       mant;
  logic signed [9:0] exp_s;
  logic [31:0]       result_d;

  // Stage 2 can take new data when it is empty or its result leaves now;
  // stage 1 likewise depends only on stage 2, so in_ready never sees in_valid.
  assign s2_load      = !s2_valid_q || bus.out_ready;
  assign s1_load      = !s1_valid_q || s2_load;
  assign bus.in_ready = s1_load;
  assign bus.out_valid = s2_valid_q;
  assign bus.result_o  = result_q;

  // Stage 1 datapath: 26-bit signed sum, result sign and magnitude.
  always_comb begin
    sum_d  = {bus.signeda[24], bus.signeda} + {bus.signedb[24], bus.signedb};
    sign_d = (bus.sign_a == bus.sign_b) ? bus.sign_a : sum_d[25];
    mag_d  = sum_d[25] ? (26'd0 - sum_d) : sum_d;
  end

  // Stage 1 occupancy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= bus.in_valid;
    end
  end

  // Stage 1 payload; only captured on an accepted input, so no reset needed.
  always_ff @(posedge clk) begin
    if (s1_load && bus.in_valid) begin
      s1_mag_q  <= mag_d;
      s1_sign_q <= sign_d;
      s1_exp_q  <= exp_in_w();
    end
  end

  function automatic logic [7:0] exp_in_w();
    return bus.exp_in;
  endfunction

  // Stage 2 datapath: find the leading one, shift, adjust exponent, pack.
  always_comb begin
    lead     = 5'd0;
    shamt    = 5'd0;
    mant     = 23'd0;
    exp_s    = 10'sd0;
    result_d = 32'd0;
    for (int i = 0; i < 24; i++) begin
      if (s1_mag_q[i]) begin
        lead = i[4:0];
      end
    end
    shamt = 5'd23 - lead;
    if (s1_mag_q[25]) begin
      mant  = s1_mag_q[24:2];
      exp_s = $signed({2'b00, s1_exp_q}) + 10'sd2;
    end else if (s1_mag_q[24]) begin
      mant  = s1_mag_q[23:1];
      exp_s = $signed({2'b00, s1_exp_q}) + 10'sd1;
    end else begin
      mant  = s1_mag_q[22:0] << shamt;
      exp_s = $signed({2'b00, s1_exp_q}) - $signed({5'b00000, shamt});
    end
    if (s1_mag_q == 26'd0) begin
      result_d = 32'h0000_0000;
    end else if (exp_s >= 10'sd255) begin
      result_d = {s1_sign_q, 8'hFF, 23'h0};
    end else if (exp_s <= 10'sd0) begin
      result_d = {s1_sign_q, 31'h0};
    end else begin
      result_d = {s1_sign_q, exp_s[7:0], mant};
    end
  end

  // Stage 2 output register; holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      result_q   <= 32'h0000_0000;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
      end
    end
  end

endmodule
